// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - hazard, forwarding, memory-wait and branch-flush control for a 3-stage D/E/W pipeline
module pipeline_controller #(
  parameter int FLUSH_DEPTH = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_valid,
  input  logic [4:0]             d_rs1,
  input  logic [4:0]             d_rs2,
  input  logic                   d_rs1_used,
  input  logic                   d_rs2_used,
  input  logic [4:0]             d_rd,
  input  logic                   d_wen,
  input  logic                   d_is_load,
  input  logic                   d_is_mem,
  input  logic                   e_branch_taken,
  input  logic                   mem_ack,
  output logic                   pc_en,
  output logic                   f_d_en,
  output logic                   d_e_en,
  output logic                   e_w_en,
  output logic                   f_d_flush,
  output logic                   d_e_bubble,
  output logic [1:0]             fwd_rs1_sel,
  output logic [1:0]             fwd_rs2_sel,
  output logic                   mem_req,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, BR_FLUSH} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
    logic       is_mem;
  } rec_t;

  localparam logic [8:0] TMO_LAST   = 9'(MEM_TIMEOUT - 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

  state_t                 state, state_n;
  rec_t                   e_r, w_r, d_rec;
  logic [2:0]             fl_cnt, fl_cnt_n;
  logic [8:0]             tmo_cnt;
  logic                   mem_err_r;
  logic [STALL_CNT_W-1:0] stall_r;
  logic                   br_taken, load_use, tmo_hit, released;

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input rec_t e, input rec_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && rs != 5'd0) begin
      if (e.valid && e.wen && e.rd == rs && !e.is_load) sel = 2'b01;
      else if (w.valid && w.wen && w.rd == rs)          sel = 2'b10;
    end
    return sel;
  endfunction

  function automatic logic load_hit(input logic used, input logic [4:0] rs, input rec_t e);
    return used && rs != 5'd0 && e.valid && e.wen && e.is_load && e.rd == rs;
  endfunction

  always_comb begin
    d_rec    = {d_valid, d_rd, d_wen, d_is_load, d_is_mem};
    br_taken = e_branch_taken && e_r.valid;
    load_use = load_hit(d_rs1_used, d_rs1, e_r) || load_hit(d_rs2_used, d_rs2, e_r);
    tmo_hit  = (state == MEM_WAIT) && (tmo_cnt == TMO_LAST);
    // The ack (or timeout) cycle of MEM_WAIT behaves exactly like a RUN cycle.
    released = (state == RUN) || ((state == MEM_WAIT) && (mem_ack || tmo_hit));

    pc_en       = 1'b1;
    f_d_en      = 1'b1;
    d_e_en      = 1'b1;
    e_w_en      = 1'b1;
    f_d_flush   = 1'b0;
    d_e_bubble  = 1'b0;
    mem_req     = 1'b0;
    fwd_rs1_sel = 2'b00;
    fwd_rs2_sel = 2'b00;
    state_n     = state;
    fl_cnt_n    = fl_cnt;

    if (!rst) begin
      fwd_rs1_sel = fwd_sel(d_rs1_used, d_rs1, e_r, w_r);
      fwd_rs2_sel = fwd_sel(d_rs2_used, d_rs2, e_r, w_r);
      case (state)
        BR_FLUSH: begin
          f_d_flush  = 1'b1;
          d_e_bubble = 1'b1;
          if (fl_cnt <= 3'd1) state_n = RUN;
          else                fl_cnt_n = fl_cnt - 3'd1;
        end
        default: begin
          mem_req = (state == MEM_WAIT);
          if (!released) begin
            pc_en  = 1'b0;
            f_d_en = 1'b0;
            d_e_en = 1'b0;
            e_w_en = 1'b0;
          end else begin
            state_n = RUN;
            if (br_taken) begin
              f_d_flush  = 1'b1;
              d_e_bubble = 1'b1;
              if (FLUSH_DEPTH > 1) begin
                state_n  = BR_FLUSH;
                fl_cnt_n = FLUSH_LOAD;
              end
            end else if (load_use) begin
              pc_en      = 1'b0;
              f_d_en     = 1'b0;
              d_e_bubble = 1'b1;
            end else if (d_valid && d_is_mem) begin
              state_n = MEM_WAIT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      e_r       <= '0;
      w_r       <= '0;
      fl_cnt    <= '0;
      tmo_cnt   <= '0;
      mem_err_r <= 1'b0;
      stall_r   <= '0;
    end else begin
      state  <= state_n;
      fl_cnt <= fl_cnt_n;
      if (d_e_en) e_r <= (d_e_bubble || !d_valid) ? '0 : d_rec;
      if (e_w_en) w_r <= e_r;
      tmo_cnt <= (state == MEM_WAIT && !released) ? tmo_cnt + 9'd1 : 9'd0;
      if (tmo_hit && !mem_ack) mem_err_r <= 1'b1;
      if (!pc_en && stall_r != '1) stall_r <= stall_r + STALL_CNT_W'(1);
    end
  end

  assign mem_err     = mem_err_r && !rst;
  assign stall_count = rst ? '0 : stall_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed self-checking bench for pipeline_controller
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_rs1_used, d_rs2_used, d_wen, d_is_load, d_is_mem;
  logic        e_branch_taken, mem_ack;
  logic        pc_en, f_d_en, d_e_en, e_w_en, f_d_flush, d_e_bubble, mem_req, mem_err;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [15:0] stall_count;
  logic [6:0]  ctl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_en, f_d_en, d_e_en, e_w_en, f_d_flush, d_e_bubble, mem_req};

  pipeline_controller #(
    .FLUSH_DEPTH(2),
    .MEM_TIMEOUT(4),
    .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .d_rd(d_rd), .d_wen(d_wen), .d_is_load(d_is_load), .d_is_mem(d_is_mem),
    .e_branch_taken(e_branch_taken), .mem_ack(mem_ack),
    .pc_en(pc_en), .f_d_en(f_d_en), .d_e_en(d_e_en), .e_w_en(e_w_en),
    .f_d_flush(f_d_flush), .d_e_bubble(d_e_bubble),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .mem_req(mem_req), .mem_err(mem_err), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic w, input logic ld, input logic m);
    d_valid = v; d_rs1 = r1; d_rs2 = r2; d_rs1_used = u1; d_rs2_used = u2;
    d_rd = rd; d_wen = w; d_is_load = ld; d_is_mem = m;
  endtask

  task automatic idle();
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; e_branch_taken = 1'b1;
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    #1;
    chk("rst_ctl", 32'(ctl), 32'h78);
    chk("rst_fwd", 32'({fwd_rs1_sel, fwd_rs2_sel}), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_stall", 32'(stall_count), 32'h0);

    rst = 1'b0; e_branch_taken = 1'b0;
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1 chk("alu_add_ctl", 32'(ctl), 32'h78);
    tick();
    set_d(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("alu_dep_fwd1", 32'(fwd_rs1_sel), 32'h1);
    chk("alu_dep_fwd2", 32'(fwd_rs2_sel), 32'h0);
    chk("alu_dep_ctl", 32'(ctl), 32'h78);
    tick();
    set_d(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("w_fwd1", 32'(fwd_rs1_sel), 32'h2);
    chk("e_fwd2", 32'(fwd_rs2_sel), 32'h1);
    tick();

    set_d(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1 chk("x0_fwd", 32'({fwd_rs1_sel, fwd_rs2_sel}), 32'h0);
    tick();

    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    set_d(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    chk("e_over_w_fwd1", 32'(fwd_rs1_sel), 32'h1);
    chk("unused_fwd2", 32'(fwd_rs2_sel), 32'h0);
    tick();
    idle(); tick(); tick();

    // load-use: lw x7; add x8,x7,x7 with memory acking immediately
    mem_ack = 1'b1;
    set_d(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
    #1 chk("lw_ctl", 32'(ctl), 32'h78);
    tick();
    set_d(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall_ctl", 32'(ctl), 32'h1B);
    chk("lu_stall_cnt0", 32'(stall_count), 32'h0);
    tick();
    #1;
    chk("lu_after_ctl", 32'(ctl), 32'h78);
    chk("lu_fwd", 32'({fwd_rs1_sel, fwd_rs2_sel}), 32'hA);
    chk("lu_stall_cnt1", 32'(stall_count), 32'h1);
    tick();

    // store with ack in the third wait cycle; branch ignored while waiting
    mem_ack = 1'b0;
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("sw_ctl", 32'(ctl), 32'h78);
    tick();
    idle(); e_branch_taken = 1'b1;
    #1 chk("mw1_ctl", 32'(ctl), 32'h01);
    tick();
    e_branch_taken = 1'b0;
    #1 chk("mw2_ctl", 32'(ctl), 32'h01);
    tick();
    mem_ack = 1'b1;
    #1 chk("mw_ack_ctl", 32'(ctl), 32'h79);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("mw_done_ctl", 32'(ctl), 32'h78);
    chk("mw_stall_cnt", 32'(stall_count), 32'h3);

    // timeout with MEM_TIMEOUT=4 and no ack
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("tmo_wait%0d_ctl", i), 32'(ctl), 32'h01);
      chk($sformatf("tmo_wait%0d_err", i), 32'(mem_err), 32'h0);
      tick();
    end
    #1 chk("tmo_rel_ctl", 32'(ctl), 32'h79);
    tick();
    #1;
    chk("tmo_done_ctl", 32'(ctl), 32'h78);
    chk("tmo_err", 32'(mem_err), 32'h1);
    chk("tmo_stall_cnt", 32'(stall_count), 32'h6);
    tick();

    // taken branch, FLUSH_DEPTH=2, reset in second flush cycle
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    e_branch_taken = 1'b1;
    set_d(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b1);
    #1 chk("br1_ctl", 32'(ctl), 32'h7E);
    tick();
    e_branch_taken = 1'b0;
    #1;
    chk("br2_ctl", 32'(ctl), 32'h7E);
    chk("br2_err_sticky", 32'(mem_err), 32'h1);
    rst = 1'b1;
    #1;
    chk("br_rst_ctl", 32'(ctl), 32'h78);
    chk("br_rst_err", 32'(mem_err), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("br_post_ctl", 32'(ctl), 32'h78);
    chk("br_post_err", 32'(mem_err), 32'h0);
    chk("br_post_stall", 32'(stall_count), 32'h0);
    tick();

    // reset abandons a memory wait
    idle();
    #1 chk("mw_rst_pre", 32'(ctl), 32'h01);
    rst = 1'b1;
    #1 chk("mw_rst_ctl", 32'(ctl), 32'h78);
    tick();
    rst = 1'b0;
    #1 chk("mw_abandon1", 32'(ctl), 32'h78);
    tick();
    #1 chk("mw_abandon2", 32'(ctl), 32'h78);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
